// File: rtl/mem_loader_pkg.sv
// Shared definitions for the program-memory loader.
// Provides the loader state encoding used by mem_loader.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_DONE  = 2'd2,
    LD_ERROR = 2'd3
  } ld_state_t;

endpackage

// File: rtl/mem_loader.sv
// Sequential byte-stream writer into a bounded program memory window.
// Ports: clk/reset; start, base_addr, length, lower_bound, upper_bound
// (load setup); in_data/in_valid/in_ready (stream); wr_en/wr_addr/wr_data
// (memory write port); busy, done, error, checksum (status).
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   base_addr,
  input  logic [AW+1:0] length,
  input  logic [AW:0]   lower_bound,
  input  logic [AW:0]   upper_bound,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW:0]   wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [7:0]    checksum
);

  localparam logic [AW:0]   ADDR_MAX = '1;
  localparam logic [AW:0]   ADDR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW+1:0] LEN_ONE  = {{(AW+1){1'b0}}, 1'b1};

  ld_state_t     state, state_nxt;
  logic [AW:0]   addr, addr_nxt;
  logic [AW+1:0] rem, rem_nxt;
  logic [7:0]    cs_nxt;
  logic          we_nxt;
  logic [AW:0]   wa_nxt;
  logic [DW-1:0] wd_nxt;
  logic          in_win;

  assign in_win = (addr >= lower_bound) && (addr <= upper_bound);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LD_IDLE;
      addr     <= '0;
      rem      <= '0;
      checksum <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      rem      <= rem_nxt;
      checksum <= cs_nxt;
      wr_en    <= we_nxt;
      wr_addr  <= wa_nxt;
      wr_data  <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rem_nxt   = rem;
    cs_nxt    = checksum;
    we_nxt    = 1'b0;
    wa_nxt    = wr_addr;
    wd_nxt    = wr_data;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state)
      LD_LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_win) begin
            we_nxt   = 1'b1;
            wa_nxt   = addr;
            wd_nxt   = in_data;
            cs_nxt   = checksum + in_data;
            addr_nxt = addr + ADDR_ONE;
            rem_nxt  = rem - LEN_ONE;
            // The last address may still take the final byte; only
            // further bytes past it would wrap.
            if (rem == LEN_ONE)
              state_nxt = LD_DONE;
            else if (addr == ADDR_MAX)
              state_nxt = LD_ERROR;
          end else begin
            state_nxt = LD_ERROR;
          end
        end
      end
      default: begin
        done  = (state == LD_DONE);
        error = (state == LD_ERROR);
        if (start) begin
          addr_nxt  = base_addr;
          rem_nxt   = length;
          cs_nxt    = '0;
          state_nxt = (length == '0) ? LD_DONE : LD_LOAD;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader with a transaction-level model.
// Drives directed and randomized loads and compares writes and status.
module tb_mem_loader;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int AMAX = (1 << (AW + 1)) - 1;

  logic          clk = 0;
  logic          reset = 1;
  logic          start = 0;
  logic [AW:0]   base_addr = '0;
  logic [AW+1:0] length = '0;
  logic [AW:0]   lower_bound = '0;
  logic [AW:0]   upper_bound = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 0;
  logic          in_ready, wr_en, busy, done, error;
  logic [AW:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    checksum;

  int tests = 0;
  int fails = 0;

  int bytes_q[$];
  int cap_a[$], cap_d[$];
  int exp_a[$], exp_d[$];
  int exp_cs, exp_acc;
  bit exp_err;

  mem_loader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .length(length),
    .lower_bound(lower_bound), .upper_bound(upper_bound),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      cap_a.push_back(int'(wr_addr));
      cap_d.push_back(int'(wr_data));
    end
  end

  task automatic model(input int b, input int n, input int lo, input int hi);
    exp_a.delete();
    exp_d.delete();
    exp_cs = 0;
    exp_acc = 0;
    exp_err = 0;
    for (int i = 0; i < n; i++) begin
      int a;
      a = b + i;
      exp_acc++;
      if (a < lo || a > hi) begin
        exp_err = 1;
        break;
      end
      exp_a.push_back(a);
      exp_d.push_back(bytes_q[i]);
      exp_cs = (exp_cs + bytes_q[i]) % 256;
      if (a == AMAX && i < n - 1) begin
        exp_err = 1;
        break;
      end
    end
  endtask

  task automatic run_load(input int b, input int n, input int lo,
                          input int hi, input int stall, input string nm);
    int idx, cyc;
    bit v, rdy, lst_ok;
    model(b, n, lo, hi);
    @(negedge clk);
    cap_a.delete();
    cap_d.delete();
    base_addr = b[AW:0];
    length = n[AW+1:0];
    lower_bound = lo[AW:0];
    upper_bound = hi[AW:0];
    in_valid = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    tests++;
    if (n == 0) begin
      if (done !== 1'b1 || busy !== 1'b0)
        begin fails++; $display("FAIL %s start_resp: done=%b busy=%b want done=1 busy=0", nm, done, busy); end
    end else begin
      if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0)
        begin fails++; $display("FAIL %s start_resp: busy=%b done=%b error=%b want 1,0,0", nm, busy, done, error); end
    end
    idx = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 400) begin
      v = ($urandom_range(99) >= stall) && (idx < bytes_q.size());
      in_valid = v;
      in_data = (idx < bytes_q.size()) ? 8'(bytes_q[idx]) : 8'h00;
      rdy = in_ready;
      @(negedge clk);
      if (v && rdy) idx++;
      cyc++;
    end
    in_valid = 0;
    tests++;
    if (cyc >= 400)
      begin fails++; $display("FAIL %s timeout: busy still %b after %0d cycles", nm, busy, cyc); end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (idx != exp_acc)
      begin fails++; $display("FAIL %s accepted: got %0d want %0d", nm, idx, exp_acc); end
    lst_ok = (cap_a.size() == exp_a.size());
    if (lst_ok)
      foreach (exp_a[i])
        if (cap_a[i] != exp_a[i] || cap_d[i] != exp_d[i]) lst_ok = 0;
    tests++;
    if (!lst_ok)
      begin fails++; $display("FAIL %s writes: got %0d writes want %0d (first got a=%0d d=%0h want a=%0d d=%0h)", nm, cap_a.size(), exp_a.size(), (cap_a.size() > 0) ? cap_a[0] : -1, (cap_d.size() > 0) ? cap_d[0] : -1, (exp_a.size() > 0) ? exp_a[0] : -1, (exp_d.size() > 0) ? exp_d[0] : -1); end
    tests++;
    if (done !== !exp_err || error !== exp_err)
      begin fails++; $display("FAIL %s status: done=%b error=%b want done=%b error=%b", nm, done, error, !exp_err, exp_err); end
    tests++;
    if (checksum !== 8'(exp_cs))
      begin fails++; $display("FAIL %s checksum: got %02h want %02h", nm, checksum, 8'(exp_cs)); end
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || wr_en !== 1'b0)
      begin fails++; $display("FAIL %s idle_out: busy=%b in_ready=%b wr_en=%b want 0", nm, busy, in_ready, wr_en); end
  endtask

  task automatic check_zero(input string nm);
    tests++;
    if (in_ready !== 0 || wr_en !== 0 || busy !== 0 || done !== 0 ||
        error !== 0 || wr_addr !== '0 || wr_data !== '0 || checksum !== '0)
      begin fails++; $display("FAIL %s: rdy=%b we=%b busy=%b done=%b err=%b wa=%0d wd=%02h cs=%02h want all 0", nm, in_ready, wr_en, busy, done, error, wr_addr, wr_data, checksum); end
  endtask

  task automatic test_reset();
    reset = 1;
    start = 1;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    tests++;
    if (busy !== 0 || done !== 0)
      begin fails++; $display("FAIL start_vs_reset: busy=%b done=%b want 0,0", busy, done); end
    start = 0;
    reset = 0;
  endtask

  task automatic test_basic();
    bytes_q = '{8'h0A, 8'h14, 8'h20};
    run_load(2, 3, 0, 31, 0, "basic");
    tests++;
    if (checksum !== 8'h3E)
      begin fails++; $display("FAIL basic_cs_const: got %02h want 3e", checksum); end
  endtask

  task automatic test_stall();
    bytes_q = '{8'h0A, 8'h14, 8'h20};
    run_load(2, 3, 0, 31, 70, "stall");
  endtask

  task automatic test_zero_len();
    bytes_q = '{};
    run_load(9, 0, 0, 31, 0, "zero_len");
  endtask

  task automatic test_bound();
    bytes_q = '{1, 2, 3, 4};
    run_load(6, 4, 4, 7, 0, "bound");
  endtask

  task automatic test_wrap();
    bytes_q = '{8'h55, 8'h66, 8'h77};
    run_load(30, 3, 0, 31, 0, "wrap");
  endtask

  task automatic test_wrap_exact();
    bytes_q = '{8'hF0, 8'h0F};
    run_load(30, 2, 0, 31, 20, "wrap_exact");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    base_addr = '0;
    length = 6'd3;
    lower_bound = '0;
    upper_bound = 5'd31;
    start = 1;
    @(negedge clk);
    start = 0;
    in_valid = 1;
    in_data = 8'h11;
    @(negedge clk);
    in_valid = 0;
    #2 reset = 1;
    #1 check_zero("reset_mid");
    @(negedge clk);
    reset = 0;
    bytes_q = '{8'h2A};
    run_load(0, 1, 0, 31, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      int b, n, lo, hi;
      b = $urandom_range(AMAX);
      n = $urandom_range(12);
      lo = $urandom_range(AMAX);
      hi = $urandom_range(AMAX);
      if (k % 2 == 0) begin lo = 0; hi = AMAX; end
      else if (lo > hi) begin int t; t = lo; lo = hi; hi = t; end
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back($urandom_range(255));
      run_load(b, n, lo, hi, $urandom_range(50), $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_bound();
    test_wrap();
    test_wrap_exact();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
